// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the load/store unit and mem_ctrl.
// Latency: none, wires only; request is valid/ready, response is a one-cycle pulse.
// Backpressure: req_ready stalls the master; responses cannot be stalled.
interface mem_ctrl_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [BUS_WIDTH-1:0] req_data;
  logic [1:0]           req_size;
  logic                 req_sign;
  logic                 rsp_valid;
  logic [BUS_WIDTH-1:0] rsp_data;
  logic                 rsp_error;
  logic                 busy;

  modport master (
    output req_valid, req_we, req_addr, req_data, req_size, req_sign,
    input  req_ready, rsp_valid, rsp_data, rsp_error, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_size, req_sign,
    output req_ready, rsp_valid, rsp_data, rsp_error, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// Data-memory port: byte-enable block RAM behind valid/ready requests, splitting word-crossing accesses.
// Latency: error 1, store 2 (split 3), load 2+READ_LATENCY (split 3+READ_LATENCY) cycles after accept.
// Backpressure: one request in flight; req_ready is high only in IDLE and requests are never queued.
module mem_ctrl #(
  parameter int ADDR_WIDTH   = 13,
  parameter int BUS_WIDTH    = 32,
  parameter int READ_LATENCY = 1,
  parameter int MISALIGN_EN  = 1
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);
  localparam int NB    = BUS_WIDTH / 8;
  localparam int OW    = $clog2(NB);
  localparam int WW    = ADDR_WIDTH - OW;
  localparam int DEPTH = 1 << WW;
  localparam logic [BUS_WIDTH:0] MAX_ADDR =
    {{(BUS_WIDTH + 1 - ADDR_WIDTH){1'b0}}, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, WAIT, RESP} state_t;

  state_t                 state;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic                   rsp_error_q;
  logic [BUS_WIDTH-1:0]   rsp_data_q;

  // Decode of the request currently on the bus
  logic [3:0]             a_nbytes;
  logic [OW-1:0]          a_off;
  logic [BUS_WIDTH:0]     a_end;
  logic                   a_cross;
  logic                   a_error;
  logic [2*NB-1:0]        a_be;
  logic [2*BUS_WIDTH-1:0] a_wd;

  // Registered request
  logic                   r_we;
  logic                   r_sign;
  logic [1:0]             r_size;
  logic [OW-1:0]          r_off;
  logic                   r_split;
  logic [WW-1:0]          r_word;
  logic [2*NB-1:0]        r_be;
  logic [2*BUS_WIDTH-1:0] r_wd;

  // RAM port and read pipeline
  logic [BUS_WIDTH-1:0]    ram [DEPTH];
  logic                    ram_wr;
  logic                    ram_rd;
  logic                    ram_hi;
  logic                    ram_last;
  logic [WW-1:0]           ram_addr;
  logic [NB-1:0]           ram_be;
  logic [BUS_WIDTH-1:0]    ram_wd;
  logic [BUS_WIDTH-1:0]    pipe_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [BUS_WIDTH-1:0]    out_dat;
  logic                    out_vld;
  logic                    out_last;
  logic [BUS_WIDTH-1:0]    lo_word;

  // Load assembly
  logic [2*BUS_WIDTH-1:0] ld_win;
  logic [BUS_WIDTH-1:0]   ld_raw;
  logic [BUS_WIDTH-1:0]   ld_mask;
  logic [BUS_WIDTH-1:0]   ld_res;
  logic                   ld_msb;
  logic                   ld_full;

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = ~req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_data  = rsp_data_q;

  // Classify the incoming request and pre-shift store data/enables over a two-word window
  always_comb begin
    a_nbytes = 4'd1 << bus.req_size;
    a_off    = bus.req_addr[OW-1:0];
    a_end    = {1'b0, bus.req_addr} + (BUS_WIDTH+1)'(a_nbytes) - (BUS_WIDTH+1)'(1);
    a_cross  = (5'(a_off) + 5'(a_nbytes)) > 5'(NB);
    a_error  = (a_end > MAX_ADDR)
            || (bus.req_size == 2'd3 && BUS_WIDTH == 32)
            || (a_cross && MISALIGN_EN == 0);
    a_be     = (((2*NB)'(1) << a_nbytes) - (2*NB)'(1)) << a_off;
    a_wd     = {{BUS_WIDTH{1'b0}}, bus.req_data} << {a_off, 3'b000};
  end

  // Capture request fields on accept; they stay stable for the whole access
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      r_we    <= bus.req_we;
      r_sign  <= bus.req_sign;
      r_size  <= bus.req_size;
      r_off   <= a_off;
      r_split <= a_cross;
      r_word  <= bus.req_addr[ADDR_WIDTH-1:OW];
      r_be    <= a_be;
      r_wd    <= a_wd;
    end
  end

  // RAM access for the current beat; reset in the same cycle drops the beat
  always_comb begin
    ram_hi   = (state == BEAT1);
    ram_wr   = (state == BEAT0 || state == BEAT1) && r_we && !rst;
    ram_rd   = (state == BEAT0 || state == BEAT1) && !r_we && !rst;
    ram_last = ram_hi || !r_split;
    ram_addr = ram_hi ? r_word + WW'(1) : r_word;
    ram_be   = ram_hi ? r_be[2*NB-1:NB] : r_be[NB-1:0];
    ram_wd   = ram_hi ? r_wd[2*BUS_WIDTH-1:BUS_WIDTH] : r_wd[BUS_WIDTH-1:0];
  end

  // Byte-enable write, registered read, and extra output pipeline stages
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
      end
    end
    if (ram_rd) pipe_dat[0] <= ram[ram_addr];
    for (int i = 1; i < READ_LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  // Valid and last-beat tags travel alongside the read data
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld  <= (pipe_vld << 1)  | READ_LATENCY'(ram_rd);
      pipe_last <= (pipe_last << 1) | READ_LATENCY'(ram_last);
    end
  end

  assign out_dat  = pipe_dat[READ_LATENCY-1];
  assign out_vld  = pipe_vld[READ_LATENCY-1];
  assign out_last = pipe_last[READ_LATENCY-1];

  // Hold beat0 read data until beat1 arrives
  always_ff @(posedge clk) begin
    if (out_vld && !out_last) lo_word <= out_dat;
  end

  // Align the loaded bytes to lane 0 and extend from the access width
  always_comb begin
    ld_win  = r_split ? {out_dat, lo_word} : {{BUS_WIDTH{1'b0}}, out_dat};
    ld_raw  = BUS_WIDTH'(ld_win >> {r_off, 3'b000});
    ld_full = (r_size == 2'd3) || (BUS_WIDTH == 32 && r_size == 2'd2);
    case (r_size)
      2'd0:    begin ld_mask = BUS_WIDTH'(8'hFF);         ld_msb = ld_raw[7];  end
      2'd1:    begin ld_mask = BUS_WIDTH'(16'hFFFF);      ld_msb = ld_raw[15]; end
      default: begin ld_mask = BUS_WIDTH'(32'hFFFF_FFFF); ld_msb = ld_raw[31]; end
    endcase
    if (ld_full) ld_res = ld_raw;
    else         ld_res = (ld_raw & ld_mask) | ((ld_msb && !r_sign) ? ~ld_mask : '0);
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            if (a_error) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (r_split) begin
            state <= BEAT1;
          end else if (r_we) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
          end else begin
            state <= WAIT;
          end
        end
        BEAT1: begin
          if (r_we) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (out_vld && out_last) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= ld_res;
          end
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule
